// File: rtl/lift_call_panel.sv
// lift_call_panel: call-button front end for the 3-floor lift FSM.
// Synchronises raw buttons, latches pending calls (req_floor), paces the lift
// with one-cycle start pulses and runs a door-open dwell at served floors.
module lift_call_panel #(
  parameter int SYNC_STAGES = 2,
  parameter int MOVE_TICKS  = 4,
  parameter int DWELL       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic [2:0] floor_at,
  output logic [2:0] req_floor,
  output logic       start,
  output logic       door_open,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TW = $clog2(MOVE_TICKS);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [TW-1:0] TICK_RELOAD  = TW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL - 1);

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]    btn_prev_q;
  logic [2:0]    pend_q, pend_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          start_q, start_d;
  logic          door_q, door_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [2:0] rise;
  logic [2:0] hit;
  logic [2:0] clr;
  logic       floor_ok;

  // Button synchroniser chain plus previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      btn_prev_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], btn};
      btn_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~btn_prev_q;
  assign hit      = pend_q & floor_at;
  assign floor_ok = (floor_at == 3'b001) || (floor_at == 3'b010) || (floor_at == 3'b100);

  // Next-state logic: call bookkeeping, FSM, pacing and dwell counters
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    dwell_d = dwell_q;
    start_d = 1'b0;
    clr     = 3'b000;
    err_d   = err_q | ~floor_ok;

    if (!floor_ok || err_q) begin
      // Position unknown: park in IDLE, keep calls, never pulse start.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit != 3'b000) begin
            state_d = S_DOOR;
            clr     = hit;
            dwell_d = DWELL_RELOAD;
          end else if (pend_q != 3'b000) begin
            state_d = S_MOVE;
            tick_d  = TICK_RELOAD;
          end
        end
        S_MOVE: begin
          if (hit != 3'b000) begin
            state_d = S_DOOR;
            clr     = hit;
            dwell_d = DWELL_RELOAD;
          end else if (pend_q == 3'b000) begin
            state_d = S_IDLE;
          end else if (tick_q == '0) begin
            start_d = 1'b1;
            tick_d  = TICK_RELOAD;
          end else begin
            tick_d  = tick_q - TW'(1);
          end
        end
        S_DOOR: begin
          // A press at the floor being served is swallowed while the door is open.
          clr = floor_at;
          if (dwell_q == '0) state_d = S_IDLE;
          else               dwell_d = dwell_q - DW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Clear beats set on the same bit; other bits still latch.
    pend_d = (pend_q | rise) & ~clr;
    door_d = (state_d == S_DOOR);
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and registered-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      dwell_q <= '0;
      pend_q  <= 3'b000;
      start_q <= 1'b0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      dwell_q <= dwell_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      door_q  <= door_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign req_floor = pend_q;
  assign start     = start_q;
  assign door_open = door_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
